// File: rtl/bp_be_issue_buffer_mw_if.sv
// rtl/bp_be_issue_buffer_mw_if.sv - issue buffer bus: FE enqueue, scheduler lanes, commit/roll/clear
interface bp_be_issue_buffer_mw_if #(
  parameter int entry_width_p = 64,
  parameter int els_p         = 16,
  parameter int issue_width_p = 2
);
  localparam int ptr_width_lp = $clog2(els_p) + 1;
  localparam int cnt_width_lp = $clog2(issue_width_p + 1);

  logic [entry_width_p-1:0]               fe_queue_i;
  logic                                   fe_queue_v_i;
  logic                                   fe_queue_ready_o;
  logic [issue_width_p*entry_width_p-1:0] fe_queue_o;
  logic [issue_width_p-1:0]               fe_queue_v_o;
  logic [issue_width_p-1:0]               fe_queue_yumi_i;
  logic [cnt_width_lp-1:0]                deq_cnt_i;
  logic                                   roll_v_i;
  logic                                   clr_v_i;
  logic [ptr_width_lp-1:0]                occupancy_o;

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, deq_cnt_i, roll_v_i, clr_v_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, occupancy_o
  );

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, deq_cnt_i, roll_v_i, clr_v_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, occupancy_o
  );
endinterface

// File: rtl/bp_be_issue_buffer_mw.sv
// rtl/bp_be_issue_buffer_mw.sv - multi-lane BE issue buffer with write, speculative read and commit pointers
module bp_be_issue_buffer_mw #(
  parameter int entry_width_p = 64,
  parameter int els_p         = 16,
  parameter int issue_width_p = 2
) (
  input logic                     clk_i,
  input logic                     reset_i,
  bp_be_issue_buffer_mw_if.slave  io
);
  localparam int ptr_width_lp = $clog2(els_p) + 1;
  localparam int idx_width_lp = $clog2(els_p);
  localparam logic [ptr_width_lp-1:0] els_ptr_lp = ptr_width_lp'(els_p);

  logic [entry_width_p-1:0] mem [els_p];

  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic [ptr_width_lp-1:0] unissued, inflight, held, issue_cnt;
  logic                    full, enq;

  // Pointer differences are modulo 2^ptr_width_lp; the wrap bit separates full from empty
  assign held     = wptr_r - cptr_r;
  assign unissued = wptr_r - rptr_r;
  assign inflight = rptr_r - cptr_r;
  assign full     = (held == els_ptr_lp);

  assign io.fe_queue_ready_o = ~full;
  assign io.occupancy_o      = held;

  for (genvar k = 0; k < issue_width_p; k++) begin : g_lane
    logic [ptr_width_lp-1:0] lane_ptr;
    assign lane_ptr = rptr_r + ptr_width_lp'(k);
    assign io.fe_queue_o[k*entry_width_p +: entry_width_p] = mem[lane_ptr[idx_width_lp-1:0]];
    assign io.fe_queue_v_o[k] = (unissued > ptr_width_lp'(k));
  end

  always_comb begin
    issue_cnt = '0;
    for (int k = 0; k < issue_width_p; k++) begin
      issue_cnt = issue_cnt + ptr_width_lp'(io.fe_queue_yumi_i[k]);
    end
  end

  // Commit first, then roll/issue, then clear/enqueue
  always_comb begin
    cptr_n = cptr_r + ptr_width_lp'(io.deq_cnt_i);
    rptr_n = io.roll_v_i ? cptr_n : (rptr_r + issue_cnt);
    enq    = io.fe_queue_v_i & ~full & ~io.clr_v_i;
    wptr_n = io.clr_v_i ? rptr_n : (wptr_r + ptr_width_lp'(enq));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) begin
      mem[wptr_r[idx_width_lp-1:0]] <= io.fe_queue_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (!io.roll_v_i) begin
        assert ((io.fe_queue_yumi_i & (io.fe_queue_yumi_i + issue_width_p'(1))) == '0);
        assert ((io.fe_queue_yumi_i & ~io.fe_queue_v_o) == '0);
      end
      assert (ptr_width_lp'(io.deq_cnt_i) <= inflight);
    end
  end
endmodule

// File: tb/tb_bp_be_issue_buffer_mw.sv
// tb/tb_bp_be_issue_buffer_mw.sv - randomized and directed bench against a queue-based reference model
module tb_bp_be_issue_buffer_mw;
  localparam int W  = 64;
  localparam int N  = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_be_issue_buffer_mw_if #(.entry_width_p(W), .els_p(N), .issue_width_p(IW)) bus ();

  bp_be_issue_buffer_mw #(.entry_width_p(W), .els_p(N), .issue_width_p(IW)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io      (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: q holds every entry from commit point to write point, the first iss of them issued
  logic [W-1:0] q[$];
  int iss;
  int seq = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [IW-1:0] v_exp;
    for (int k = 0; k < IW; k++) v_exp[k] = (iss + k < q.size());
    chk("ready", 64'(bus.fe_queue_ready_o), 64'(q.size() < N));
    chk("v_o", 64'(bus.fe_queue_v_o), 64'(v_exp));
    chk("occupancy", 64'(bus.occupancy_o), 64'(q.size()));
    for (int k = 0; k < IW; k++)
      if (v_exp[k]) chk($sformatf("lane%0d", k), bus.fe_queue_o[k*W +: W], q[iss + k]);
  endtask

  task automatic step(bit ev, logic [W-1:0] d, logic [IW-1:0] y, logic [1:0] dq, bit rl, bit cl);
    bit rdy;
    bus.fe_queue_v_i    = ev;
    bus.fe_queue_i      = d;
    bus.fe_queue_yumi_i = y;
    bus.deq_cnt_i       = dq;
    bus.roll_v_i        = rl;
    bus.clr_v_i         = cl;
    rdy = (q.size() < N);
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(dq); i++) void'(q.pop_front());
    iss -= int'(dq);
    if (rl) iss = 0;
    else    iss += int'(y[0]) + int'(y[1]);
    if (cl) begin
      while (q.size() > iss) void'(q.pop_back());
    end else if (ev && rdy) begin
      q.push_back(d);
    end
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fe_queue_v_i = 0; bus.fe_queue_i = '0; bus.fe_queue_yumi_i = '0;
    bus.deq_cnt_i = '0; bus.roll_v_i = 0; bus.clr_v_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    iss = 0;
    chk("rst_ready", 64'(bus.fe_queue_ready_o), 64'd1);
    chk("rst_v_o", 64'(bus.fe_queue_v_o), 64'd0);
    chk("rst_occ", 64'(bus.occupancy_o), 64'd0);
  endtask

  function automatic logic [W-1:0] nxt();
    seq++;
    return {32'hc0de_0000, 32'(seq)};
  endfunction

  function automatic logic [IW-1:0] legal_yumi(int maxn);
    int n;
    n = $urandom_range(0, (maxn > IW) ? IW : maxn);
    return (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
  endfunction

  initial begin
    logic [W-1:0] e[6];
    int sent, guard, dmax, p_enq;

    // Three enqueues, lanes show the oldest two
    do_reset();
    step(1, 64'hA, 0, 0, 0, 0);
    step(1, 64'hB, 0, 0, 0, 0);
    step(1, 64'hC, 0, 0, 0, 0);
    chk("t1_v", 64'(bus.fe_queue_v_o), 64'b11);
    chk("t1_lane0", bus.fe_queue_o[63:0], 64'hA);
    chk("t1_lane1", bus.fe_queue_o[127:64], 64'hB);
    chk("t1_occ", 64'(bus.occupancy_o), 64'd3);
    step(0, 0, 2'b11, 0, 0, 0);
    step(0, 0, 2'b00, 2, 0, 0);
    chk("t2_v", 64'(bus.fe_queue_v_o), 64'b01);
    chk("t2_lane0", bus.fe_queue_o[63:0], 64'hC);
    chk("t2_occ", 64'(bus.occupancy_o), 64'd1);

    // Fill to full, drop the 17th write, free space by issue+commit
    do_reset();
    for (int i = 0; i < N; i++) step(1, nxt(), 0, 0, 0, 0);
    chk("t3_full", 64'(bus.fe_queue_ready_o), 64'd0);
    step(1, 64'hdead, 0, 0, 0, 0);
    chk("t3_drop_occ", 64'(bus.occupancy_o), 64'd16);
    step(0, 0, 2'b11, 0, 0, 0);
    step(0, 0, 2'b00, 2, 0, 0);
    chk("t3_ready_after_commit", 64'(bus.fe_queue_ready_o), 64'd1);
    chk("t3_occ", 64'(bus.occupancy_o), 64'd14);

    // Issue four, then commit one together with a rollback
    do_reset();
    for (int i = 0; i < 6; i++) begin e[i] = nxt(); step(1, e[i], 0, 0, 0, 0); end
    step(0, 0, 2'b11, 0, 0, 0);
    step(0, 0, 2'b11, 0, 0, 0);
    step(0, 0, 2'b00, 1, 1, 0);
    chk("t4_lane0", bus.fe_queue_o[63:0], e[1]);
    chk("t4_occ", 64'(bus.occupancy_o), 64'd5);

    // Clear with a simultaneous enqueue: enqueue suppressed, unissued entries dropped
    do_reset();
    for (int i = 0; i < 5; i++) step(1, nxt(), 0, 0, 0, 0);
    step(0, 0, 2'b11, 0, 0, 0);
    step(1, 64'hbad, 0, 0, 0, 1);
    chk("t5_v", 64'(bus.fe_queue_v_o), 64'd0);
    chk("t5_occ", 64'(bus.occupancy_o), 64'd2);

    // Stream 40 entries through the 16-deep store so indices wrap twice
    do_reset();
    sent = 0;
    guard = 0;
    while ((sent < 40 || q.size() > 0) && guard < 400) begin
      bit ev;
      logic [IW-1:0] y;
      ev = (sent < 40) && (q.size() < N);
      y  = (q.size() - iss >= 2) ? 2'b11 : (q.size() - iss == 1) ? 2'b01 : 2'b00;
      step(ev, nxt(), y, 2'((iss > 2) ? 2 : iss), 0, 0);
      if (ev) sent++;
      guard++;
    end
    chk("t6_drained", 64'(guard < 400), 64'd1);

    // Random traffic in phases that alternately fill and drain the buffer
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      p_enq = (ph % 2 == 0) ? 9 : 3;
      for (int c = 0; c < 250; c++) begin
        bit ev, rl, cl;
        logic [IW-1:0] y;
        ev = ($urandom_range(0, 9) < p_enq);
        if (ev && q.size() >= N) ev = ($urandom_range(0, 3) == 0);
        y    = ($urandom_range(0, 9) < 10 - p_enq) ? legal_yumi(q.size() - iss) : 2'b00;
        dmax = (iss > 2) ? 2 : iss;
        rl   = ($urandom_range(0, 24) == 0);
        cl   = ($urandom_range(0, 39) == 0);
        step(ev, nxt(), y, 2'($urandom_range(0, dmax)), rl, cl);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
